ddr_rd_burst_gen: RTL and testbench
===================================

Name: ddr_rd_burst_gen

Overview:
- Downstream of the DDR-to-PE configuration stage; one instance per DDR read channel (ddr1, ddr2).
- Consumes a start pulse plus a strided read descriptor: st_addr, burst, step, burst_num.
- Issues AXI-style read-address requests, split into sub-bursts of at most MAX_LEN beats.
- Forwards returned read data to the buffer side with backpressure, and reports a level done once every requested beat has been delivered.

Parameters:
- ADDR_W, 32, DDR byte-address width.
- BURST_W, 16, width of the burst and burst_num descriptor fields.
- DATA_W, 256, read data width.
- BYTES_PER_BEAT, 32, address increment per data beat (power of two).
- MAX_LEN, 16, maximum beats per issued sub-burst (1..256).
- MAX_OUTSTANDING, 4, maximum issued-but-incomplete sub-bursts.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle descriptor strobe
- done  out  1  level; high when idle, low while a descriptor is in progress
- st_addr  in  ADDR_W  byte address of the first row
- burst  in  BURST_W  beats per row
- step  in  ADDR_W  byte stride between row start addresses
- burst_num  in  BURST_W  number of rows
- ar_valid  out  1  read-address request valid
- ar_ready  in  1  read-address accept
- ar_addr  out  ADDR_W  sub-burst byte address
- ar_len  out  8  sub-burst beats minus 1
- r_valid  in  1  read data valid
- r_ready  out  1  read data ready, equal to buf_ready
- r_data  in  DATA_W  read data
- r_last  in  1  last beat of a sub-burst
- buf_valid  out  1  forwarded data valid
- buf_ready  in  1  buffer accept
- buf_data  out  DATA_W  forwarded data

Behaviour:
- Clocking and reset: one clock domain; rst is synchronous and active-high, clock port is clk.
- Reset values: done=1, ar_valid=0, ar_addr=0, ar_len=0, all counters 0, FSM=IDLE.
- Reset mid-operation aborts everything. The state, outstanding count and beat counters clear. Beats still in flight afterwards are passed through on the data path but never counted.
- FSM IDLE:
  - start latches the descriptor and drops done on the next cycle.
  - If burst==0 or burst_num==0 the block stays IDLE with done=1 (no-op, no requests issued).
  - Otherwise it goes to ISSUE, with row_addr=st_addr, row_cnt=0 and row_rem=burst.
- FSM ISSUE, request generation:
  - Drive ar_valid with ar_addr=cur_addr and ar_len=min(row_rem,MAX_LEN)-1.
  - ar_valid is asserted only when outstanding<MAX_OUTSTANDING.
  - Once asserted, ar_valid, ar_addr and ar_len hold stable until ar_ready.
- FSM ISSUE, on ar_valid&&ar_ready:
  - cur_addr += (ar_len+1)*BYTES_PER_BEAT.
  - row_rem -= ar_len+1.
  - When row_rem reaches 0: row_cnt++, row_addr+=step, cur_addr=new row_addr, row_rem=burst.
  - After the last sub-burst of row burst_num-1 is accepted, go to DRAIN.
- Address arithmetic is modulo 2^ADDR_W (wrap-around, no error).
- FSM DRAIN: wait until outstanding==0 and recv_beats==burst*burst_num, then go to IDLE. done rises in the same cycle the FSM enters IDLE.
- Data path:
  - Combinational pass-through: buf_valid=r_valid, buf_data=r_data, r_ready=buf_ready.
  - A beat counts when r_valid&&r_ready.
  - outstanding decrements on a counted beat with r_last.
- Simultaneous events: an ar accept and an r_last completion in the same cycle leave outstanding unchanged.
- start while done=0 is ignored; no queuing.
- Latency: first ar_valid appears 1 cycle after start.
- Total beats are tracked in 2*BURST_W bits (no overflow).

Optional Feature:
- Macro DDR_RD_4K_SPLIT_EN.
- When defined:
  - A sub-burst is additionally limited so it does not cross a 4096-byte boundary.
  - ar_len = min(row_rem, MAX_LEN, (4096-cur_addr[11:0])/BYTES_PER_BEAT)-1.
- When undefined: only the MAX_LEN split applies.

Test Plan:
- Single aligned row:
  - Stimulus: st_addr=0x1000, burst=16, burst_num=1, ar_ready/buf_ready held 1.
  - Response: one request with ar_addr=0x1000, ar_len=15; done rises after the 16th beat with r_last.
- Row split:
  - Stimulus: burst=40, MAX_LEN=16, st_addr=0.
  - Response: requests (0x0,15), (0x200,15), (0x400,7); done after 40 beats.
- Strided rows:
  - Stimulus: st_addr=0x100, burst=2, step=0x800, burst_num=3.
  - Response: requests at 0x100, 0x900 and 0x1100, each with ar_len=1.
- Outstanding limit and backpressure:
  - Stimulus: burst=16, burst_num=8, MAX_LEN=16, no r_valid for 50 cycles, then toggle buf_ready.
  - Response: exactly 4 requests are accepted, then ar_valid stays low until the first r_last. No beat is lost; done rises after 128 beats.
- No-op and busy-start:
  - Stimulus: start with burst_num=0.
  - Response: no ar_valid and done stays 1.
  - Stimulus: start pulsed again during an active transfer.
  - Response: ignored; the request count is unchanged.
- 4K split (DDR_RD_4K_SPLIT_EN):
  - Stimulus: st_addr=0xF80, burst=16.
  - Response: requests (0xF80,3) and (0x1000,11).
  - Without the macro: a single request (0xF80,15).

Source files
------------

// File: rtl/ddr_rd_burst_gen.sv
// Strided DDR read burst generator: splits rows into AXI read sub-bursts.
// Define DDR_RD_4K_SPLIT_EN to also keep sub-bursts inside 4 KiB pages.
module ddr_rd_burst_gen #(
  parameter int ADDR_W          = 32,
  parameter int BURST_W         = 16,
  parameter int DATA_W          = 256,
  parameter int BYTES_PER_BEAT  = 32,
  parameter int MAX_LEN         = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [BURST_W-1:0] burst,
  input  logic [ADDR_W-1:0] step,
  input  logic [BURST_W-1:0] burst_num,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  output logic [7:0]        ar_len,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_last,
  output logic              buf_valid,
  input  logic              buf_ready,
  output logic [DATA_W-1:0] buf_data
);

  localparam int SH = $clog2(BYTES_PER_BEAT);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = 2 * BURST_W;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  state_t             r_state;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_num;
  logic [BURST_W-1:0] r_row_cnt;
  logic [BURST_W-1:0] r_row_rem;
  logic [ADDR_W-1:0]  r_step;
  logic [ADDR_W-1:0]  r_row_addr;
  logic [TW-1:0]      r_total;
  logic [TW-1:0]      r_recv;
  logic [OW-1:0]      r_out;

  logic               w_acc;
  logic               w_beat;
  logic               w_cmp;
  logic [OW-1:0]      w_out_nxt;
  logic               w_can_issue;
  logic [8:0]         w_len1;
  logic [BURST_W-1:0] w_rem_after;
  logic               w_row_end;
  logic               w_last;
  logic [ADDR_W-1:0]  w_nxt_row;
  logic [ADDR_W-1:0]  w_nxt_addr;
  logic [BURST_W-1:0] w_nxt_rem;
  logic [ADDR_W-1:0]  w_req_addr;
  logic [BURST_W-1:0] w_req_rem;
  logic [31:0]        w_n;
  logic [7:0]         w_len;

  assign buf_valid = r_valid;
  assign buf_data  = r_data;
  assign r_ready   = buf_ready;

  always_comb begin
    w_acc       = ar_valid & ar_ready;
    // Beats arriving while idle (e.g. after an abort) are not counted.
    w_beat      = r_valid & buf_ready & (r_state != IDLE);
    w_cmp       = w_beat & r_last & (r_out != '0);
    w_out_nxt   = r_out + OW'(w_acc) - OW'(w_cmp);
    w_can_issue = w_out_nxt < OW'(MAX_OUTSTANDING);
    w_len1      = {1'b0, ar_len} + 9'd1;
    w_rem_after = r_row_rem - BURST_W'(w_len1);
    w_row_end   = (w_rem_after == '0);
    w_last      = w_row_end && (r_row_cnt == r_num - BURST_W'(1));
    w_nxt_row   = r_row_addr + r_step;
    w_nxt_addr  = w_row_end ? w_nxt_row
                            : ar_addr + (ADDR_W'(w_len1) << SH);
    w_nxt_rem   = w_row_end ? r_burst : w_rem_after;
    w_req_addr  = (r_state == IDLE) ? st_addr : w_nxt_addr;
    w_req_rem   = (r_state == IDLE) ? burst : w_nxt_rem;
    w_n         = 32'(w_req_rem);
    if (w_n > 32'(MAX_LEN)) w_n = 32'(MAX_LEN);
`ifdef DDR_RD_4K_SPLIT_EN
    begin
      logic [31:0] room;
      room = (32'd4096 - {20'd0, w_req_addr[11:0]}) >> SH;
      if (room == 32'd0) room = 32'd1;
      if (w_n > room) w_n = room;
    end
`endif
    w_len = 8'(w_n - 32'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      done       <= 1'b1;
      ar_valid   <= 1'b0;
      ar_addr    <= '0;
      ar_len     <= '0;
      r_burst    <= '0;
      r_num      <= '0;
      r_row_cnt  <= '0;
      r_row_rem  <= '0;
      r_step     <= '0;
      r_row_addr <= '0;
      r_total    <= '0;
      r_recv     <= '0;
      r_out      <= '0;
    end else begin
      r_out <= w_out_nxt;
      if (w_beat) r_recv <= r_recv + TW'(1);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_burst <= burst;
            r_num   <= burst_num;
            r_step  <= step;
            if (burst != '0 && burst_num != '0) begin
              r_state    <= ISSUE;
              done       <= 1'b0;
              r_row_addr <= st_addr;
              r_row_cnt  <= '0;
              r_row_rem  <= burst;
              r_recv     <= '0;
              r_total    <= TW'(burst) * TW'(burst_num);
              ar_addr    <= st_addr;
              ar_len     <= w_len;
              ar_valid   <= w_can_issue;
            end
          end
        end
        ISSUE: begin
          if (w_acc && w_last) begin
            r_state  <= DRAIN;
            ar_valid <= 1'b0;
          end else begin
            if (w_acc) begin
              ar_addr   <= w_nxt_addr;
              ar_len    <= w_len;
              r_row_rem <= w_nxt_rem;
              if (w_row_end) begin
                r_row_cnt  <= r_row_cnt + BURST_W'(1);
                r_row_addr <= w_nxt_row;
              end
            end
            ar_valid <= w_can_issue;
          end
        end
        DRAIN: begin
          if (r_out == '0 && r_recv == r_total) begin
            r_state <= IDLE;
            done    <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_rd_burst_gen.sv
// Randomized bench for ddr_rd_burst_gen against a request-list model.
// Honors DDR_RD_4K_SPLIT_EN the same way as the design.
module tb_ddr_rd_burst_gen;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         done;
  logic [31:0]  st_addr = '0;
  logic [15:0]  burst = '0;
  logic [31:0]  step = '0;
  logic [15:0]  burst_num = '0;
  logic         ar_valid;
  logic         ar_ready = 1'b0;
  logic [31:0]  ar_addr;
  logic [7:0]   ar_len;
  logic         r_valid = 1'b0;
  logic         r_ready;
  logic [255:0] r_data = '0;
  logic         r_last = 1'b0;
  logic         buf_valid;
  logic         buf_ready = 1'b0;
  logic [255:0] buf_data;

  always #5 clk = ~clk;

  ddr_rd_burst_gen dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .st_addr(st_addr), .burst(burst), .step(step),
    .burst_num(burst_num),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_last(r_last),
    .buf_valid(buf_valid), .buf_ready(buf_ready),
    .buf_data(buf_data)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
  } req_t;

  int     checks = 0;
  int     errors = 0;
  req_t   exp_q[$];
  int     beat_q[$];
  int     beat_idx = 0;
  int     m_out = 0;
  longint recv = 0;
  int     acc_cnt = 0;
  bit     hold_r = 1'b0;
  int     ar_pct = 100;
  int     br_pct = 100;
  bit     prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [7:0]  prev_len;

  task automatic chk(input string n, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", n, act, req);
    end
  endtask

  // Expected request list straight from the row/split rules.
  function automatic void build(input logic [31:0] st, input int b,
                                input logic [31:0] stp, input int num);
    logic [31:0] a;
    int rem;
    int n;
    int room;
    for (int r = 0; r < num; r++) begin
      a = st + stp * 32'(r);
      rem = b;
      while (rem > 0) begin
        n = (rem < 16) ? rem : 16;
`ifdef DDR_RD_4K_SPLIT_EN
        room = (4096 - int'(a[11:0])) / 32;
        if (room < 1) room = 1;
        if (n > room) n = room;
`else
        room = 0;
`endif
        exp_q.push_back('{a, 8'(n - 1)});
        a = a + 32'(n * 32);
        rem = rem - n;
      end
    end
  endfunction

  task automatic pin(input string n, input int idx,
                     input logic [31:0] a, input int l);
    if (idx < exp_q.size()) begin
      chk({n, "_addr"}, exp_q[idx].a, a);
      chk({n, "_len"}, exp_q[idx].l, l);
    end else begin
      chk({n, "_missing"}, exp_q.size(), idx + 1);
    end
  endtask

  // Responder and per-cycle checker.
  always @(negedge clk) begin
    ar_ready = ($urandom_range(99) < ar_pct);
    buf_ready = ($urandom_range(99) < br_pct);
    r_data = {8{$urandom}};
    if (!rst && !hold_r && beat_q.size() > 0
        && $urandom_range(3) != 0) begin
      r_valid = 1'b1;
      r_last = (beat_idx == beat_q[0] - 1);
    end else begin
      r_valid = 1'b0;
      r_last = 1'b0;
    end
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (buf_valid !== r_valid || buf_data !== r_data
          || r_ready !== buf_ready) begin
        errors++;
        $display("FAIL passthru bv=%b rv=%b rr=%b br=%b bd=%h rd=%h",
                 buf_valid, r_valid, r_ready, buf_ready,
                 buf_data, r_data);
      end
      if (ar_valid) chk("ar_limit", m_out < 4, 1);
      if (prev_stall) begin
        chk("hold_valid", ar_valid, 1);
        chk("hold_addr", ar_addr, prev_addr);
        chk("hold_len", ar_len, prev_len);
      end
      prev_stall = ar_valid && !ar_ready;
      prev_addr = ar_addr;
      prev_len = ar_len;
      if (ar_valid && ar_ready) begin
        if (exp_q.size() == 0) begin
          chk("ar_unexpected", ar_addr, 32'hdead_beef);
        end else begin
          chk("ar_addr", ar_addr, exp_q[0].a);
          chk("ar_len", ar_len, exp_q[0].l);
          void'(exp_q.pop_front());
        end
        beat_q.push_back(int'(ar_len) + 1);
        m_out++;
        acc_cnt++;
      end
      if (r_valid && buf_ready) begin
        recv++;
        beat_idx++;
        if (r_last) begin
          void'(beat_q.pop_front());
          beat_idx = 0;
          m_out--;
        end
      end
    end
  end

  task automatic run(input logic [31:0] st, input int b,
                     input logic [31:0] stp, input int num,
                     input int hold_cyc, input int busy_at);
    longint total;
    bit active;
    int cyc;
    int n_req;
    @(negedge clk);
    st_addr = st;
    burst = 16'(b);
    step = stp;
    burst_num = 16'(num);
    start = 1'b1;
    active = (b != 0 && num != 0);
    if (active) build(st, b, stp, num);
    n_req = exp_q.size();
    total = active ? longint'(b) * longint'(num) : 0;
    recv = 0;
    acc_cnt = 0;
    hold_r = (hold_cyc > 0);
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("done_after_start", done, active ? 0 : 1);
    chk("first_ar_valid", ar_valid, active ? 1 : 0);
    cyc = 0;
    while ((recv < total || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      if (cyc == busy_at) begin
        burst = 16'd7;
        burst_num = 16'd3;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      #2;
      cyc++;
      chk("done_low_busy", done, 0);
      if (hold_cyc > 0 && cyc == hold_cyc) begin
        chk("outstanding_accepts", acc_cnt, 4);
        chk("ar_valid_blocked", ar_valid, 0);
        hold_r = 1'b0;
        br_pct = 50;
      end
    end
    start = 1'b0;
    chk("transfer_timeout", cyc < 4000, 1);
    cyc = 0;
    while (!done && cyc < 6) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk("done_rise", done, 1);
    chk("beats_total", recv, total);
    chk("req_count", acc_cnt, n_req);
    chk("model_out_zero", m_out, 0);
  endtask

  initial begin
    logic [31:0] a;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_done", done, 1);
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_ar_addr", ar_addr, 0);
    chk("rst_ar_len", ar_len, 0);
    @(negedge clk);
    rst = 1'b0;

    build(32'h1000, 16, 32'h0, 1);
    chk("pin1_n", exp_q.size(), 1);
    pin("pin1", 0, 32'h1000, 15);
    exp_q.delete();
    build(32'h0, 40, 32'h0, 1);
    chk("pin2_n", exp_q.size(), 3);
    pin("pin2a", 0, 32'h0, 15);
    pin("pin2b", 1, 32'h200, 15);
    pin("pin2c", 2, 32'h400, 7);
    exp_q.delete();
    build(32'h100, 2, 32'h800, 3);
    pin("pin3a", 0, 32'h100, 1);
    pin("pin3b", 1, 32'h900, 1);
    pin("pin3c", 2, 32'h1100, 1);
    exp_q.delete();
    build(32'hF80, 16, 32'h0, 1);
`ifdef DDR_RD_4K_SPLIT_EN
    chk("pin4_n", exp_q.size(), 2);
    pin("pin4a", 0, 32'hF80, 3);
    pin("pin4b", 1, 32'h1000, 11);
`else
    chk("pin4_n", exp_q.size(), 1);
    pin("pin4a", 0, 32'hF80, 15);
`endif
    exp_q.delete();

    run(32'h1000, 16, 32'h0, 1, 0, -1);
    run(32'h0, 40, 32'h0, 1, 0, -1);
    run(32'h100, 2, 32'h800, 3, 0, -1);
    run(32'hF80, 16, 32'h0, 1, 0, -1);
    run(32'hFFFF_FFE0, 4, 32'h40, 2, 0, -1);
    run(32'h2000, 16, 32'h1000, 8, 50, -1);
    br_pct = 100;
    run(32'h40, 0, 32'h0, 3, 0, -1);
    run(32'h40, 5, 32'h0, 0, 0, -1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2;
      chk("noop_idle_done", done, 1);
      chk("noop_no_ar", ar_valid, 0);
    end
    ar_pct = 60;
    br_pct = 70;
    run(32'h3000, 24, 32'h400, 3, 0, 4);

    // Abort mid-transfer with the data path held quiet.
    @(negedge clk);
    st_addr = 32'h5000;
    burst = 16'd32;
    step = 32'h800;
    burst_num = 16'd4;
    start = 1'b1;
    build(32'h5000, 32, 32'h800, 4);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    hold_r = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    beat_q.delete();
    beat_idx = 0;
    m_out = 0;
    @(negedge clk);
    rst = 1'b0;
    hold_r = 1'b0;
    #2;
    chk("abort_done", done, 1);
    chk("abort_ar_valid", ar_valid, 0);
    chk("abort_ar_addr", ar_addr, 0);
    chk("abort_ar_len", ar_len, 0);
    run(32'h800, 3, 32'h20, 2, 0, -1);

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(3) == 0)
        a = 32'h1000 * $urandom_range(1, 64) - 32 * $urandom_range(1, 8);
      else
        a = $urandom & 32'hFFFF_FFE0;
      ar_pct = $urandom_range(30, 100);
      br_pct = $urandom_range(30, 100);
      run(a, $urandom_range(1, 40), 32'($urandom_range(0, 200) * 32),
          $urandom_range(1, 4), 0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
